// File: rtl/chip_despreader_if.sv
`default_nettype none
// ============================================================================
//  Module  : chip_despreader_if
//  Purpose : Chip-in / symbol-out bundle between the CDR, the despreader and
//            the outFIFO. outDistance exists only with DESPREADER_DIST_OUT_EN.
//  Revision: 1.0  initial release
// ============================================================================
interface chip_despreader_if;
    logic       inEnable;
    logic       inChip;
    logic [3:0] outData;
    logic       outValid;
    logic       outLock;
`ifdef DESPREADER_DIST_OUT_EN
    logic [5:0] outDistance;

    modport slave  (input  inEnable, input  inChip,
                    output outData,  output outValid, output outLock, output outDistance);
    modport master (output inEnable, output inChip,
                    input  outData,  input  outValid, input  outLock, input  outDistance);
`else
    modport slave  (input  inEnable, input  inChip,
                    output outData,  output outValid, output outLock);
    modport master (output inEnable, output inChip,
                    input  outData,  input  outValid, input  outLock);
`endif
endinterface
`default_nettype wire

// File: rtl/chip_despreader.sv
`default_nettype none
// ============================================================================
//  Module  : chip_despreader
//  Purpose : DSSS despreader for 802.15.4 O-QPSK; hunts PN[0] alignment, then
//            correlates each 32-chip word against the 16 PN sequences.
//            Optional macro DESPREADER_DIST_OUT_EN exposes outDistance.
//  Revision: 1.0  initial release
// ============================================================================
module chip_despreader #(
    parameter int THRESHOLD  = 6,
    parameter int MISS_LIMIT = 3
) (
    input wire               inClock,
    input wire               inReset,
    chip_despreader_if.slave bus
);

    // Symbol-0 chips written c0 first, so c0 lands in the MSB of the literal.
    localparam logic [31:0] c_PN0_MSB_FIRST = 32'b11011001110000110101001000101110;
    localparam logic [5:0]  c_THRESHOLD     = 6'(THRESHOLD);
    localparam logic [5:0]  c_FILL_FULL     = 6'd32;
    localparam int          c_MISS_W        = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LIMIT = c_MISS_W'(MISS_LIMIT);
    localparam logic [c_MISS_W-1:0] c_MISS_ONE   = c_MISS_W'(1);

    typedef enum logic [0:0] {
        ST_HUNT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    function automatic logic [31:0] pn_word(input int k);
        logic [31:0] w;
        int          src;
        for (int i = 0; i < 32; i++) begin
            src  = (i - 4 * (k % 8) + 32) % 32;
            w[i] = c_PN0_MSB_FIRST[31 - src];
            if ((k >= 8) && ((i % 2) == 1)) begin
                w[i] = ~w[i];
            end
        end
        return w;
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    state_t              r_state;
    logic [30:0]         r_window;
    logic [5:0]          r_fill;
    logic [4:0]          r_chip;
    logic [c_MISS_W-1:0] r_miss;
    logic [3:0]          r_data;
    logic                r_valid;

    state_t              w_state_nxt;
    logic [30:0]         w_window_nxt;
    logic [5:0]          w_fill_nxt;
    logic [4:0]          w_chip_nxt;
    logic [c_MISS_W-1:0] w_miss_nxt;
    logic [3:0]          w_data_nxt;
    logic                w_valid_nxt;

    logic [31:0]         w_window;
    logic [5:0]          w_dist [16];
    logic [5:0]          w_min_dist;
    logic [3:0]          w_min_idx;
    logic [5:0]          w_fill_inc;
    logic [c_MISS_W-1:0] w_miss_inc;

`ifdef DESPREADER_DIST_OUT_EN
    logic [5:0]          r_dist;
    logic [5:0]          w_dist_nxt;
`endif

    // Bit i of the window is chip i of the word ending with the current strobe.
    assign w_window = {bus.inChip, r_window};

    generate
        for (genvar k = 0; k < 16; k++) begin : g_pn
            localparam logic [31:0] c_PN = pn_word(k);
            assign w_dist[k] = popcount32(w_window ^ c_PN);
        end
    endgenerate

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_min_dist = w_dist[0];
        w_min_idx  = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (w_dist[k] < w_min_dist) begin
                w_min_dist = w_dist[k];
                w_min_idx  = 4'(k);
            end
        end
    end

    assign w_fill_inc = (r_fill == c_FILL_FULL) ? c_FILL_FULL : (r_fill + 6'd1);
    assign w_miss_inc = r_miss + c_MISS_ONE;

    always_comb begin
        w_state_nxt  = r_state;
        w_window_nxt = r_window;
        w_fill_nxt   = r_fill;
        w_chip_nxt   = r_chip;
        w_miss_nxt   = r_miss;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
`ifdef DESPREADER_DIST_OUT_EN
        w_dist_nxt   = r_dist;
`endif
        if (bus.inEnable) begin
            w_window_nxt = w_window[31:1];
            case (r_state)
                ST_HUNT: begin
                    w_fill_nxt = w_fill_inc;
                    if ((w_fill_inc == c_FILL_FULL) && (w_dist[0] <= c_THRESHOLD)) begin
                        w_state_nxt = ST_TRACK;
                        w_chip_nxt  = 5'd0;
                        w_miss_nxt  = '0;
`ifdef DESPREADER_DIST_OUT_EN
                        w_dist_nxt  = w_dist[0];
`endif
                    end
                end
                ST_TRACK: begin
                    w_chip_nxt = r_chip + 5'd1;
                    if (r_chip == 5'd31) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_min_idx;
`ifdef DESPREADER_DIST_OUT_EN
                        w_dist_nxt  = w_min_dist;
`endif
                        if (w_min_dist <= c_THRESHOLD) begin
                            w_miss_nxt = '0;
                        end else if (w_miss_inc == c_MISS_LIMIT) begin
                            w_state_nxt = ST_HUNT;
                            w_fill_nxt  = 6'd0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_state  <= ST_HUNT;
            r_window <= '0;
            r_fill   <= '0;
            r_chip   <= '0;
            r_miss   <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
`ifdef DESPREADER_DIST_OUT_EN
            r_dist   <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_window <= w_window_nxt;
            r_fill   <= w_fill_nxt;
            r_chip   <= w_chip_nxt;
            r_miss   <= w_miss_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
`ifdef DESPREADER_DIST_OUT_EN
            r_dist   <= w_dist_nxt;
`endif
        end
    end

    assign bus.outData  = r_data;
    assign bus.outValid = r_valid;
    assign bus.outLock  = (r_state == ST_TRACK);
`ifdef DESPREADER_DIST_OUT_EN
    assign bus.outDistance = r_dist;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chip_despreader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_chip_despreader
//  Purpose : Self-checking bench for chip_despreader (vector table, directed
//            corner sequences and randomized words against a chip-list model).
//  Revision: 1.0  initial release
// ============================================================================
module tb_chip_despreader;

    localparam int THRESHOLD  = 6;
    localparam int MISS_LIMIT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chip_despreader_if bus ();

    chip_despreader #(
        .THRESHOLD (THRESHOLD),
        .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .inClock(clk),
        .inReset(rst_n),
        .bus    (bus)
    );

    typedef struct {
        int          sym;        // -1 = all-zero word
        logic [31:0] flip;
        bit          exp_valid;
        int          exp_data;   // -1 = not checked
        bit          exp_lock;
        int          exp_dist;   // -1 = not checked
    } vec_t;

    string c_PN0_TEXT = "11011001110000110101001000101110";

    int total = 0;
    int bad   = 0;

    bit m_hist[$];
    bit m_lock;
    bit m_valid;
    int m_fill, m_pos, m_miss, m_data, m_dist;

    function automatic bit pn_chip(int k, int i);
        int  src;
        byte ch;
        bit  b;
        src = (((i - 4 * (k % 8)) % 32) + 32) % 32;
        ch  = c_PN0_TEXT[src];
        b   = (ch == 8'h31);
        if (k >= 8 && (i % 2) == 1) b = ~b;
        return b;
    endfunction

    function automatic int model_dist(int k);
        int d = 0;
        int base = m_hist.size() - 32;
        for (int i = 0; i < 32; i++)
            if (m_hist[base + i] != pn_chip(k, i)) d++;
        return d;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_lock = 0; m_valid = 0;
        m_fill = 0; m_pos = 0; m_miss = 0; m_data = 0; m_dist = 0;
    endtask

    task automatic model_step(bit c);
        int d, best, bd;
        m_hist.push_back(c);
        if (m_hist.size() > 32) void'(m_hist.pop_front());
        m_valid = 0;
        if (!m_lock) begin
            if (m_fill < 32) m_fill++;
            if (m_fill == 32) begin
                d = model_dist(0);
                if (d <= THRESHOLD) begin
                    m_lock = 1; m_pos = 0; m_miss = 0; m_dist = d;
                end
            end
        end else begin
            m_pos++;
            if (m_pos == 32) begin
                m_pos = 0;
                best  = 0;
                bd    = model_dist(0);
                for (int k = 1; k < 16; k++) begin
                    d = model_dist(k);
                    if (d < bd) begin bd = d; best = k; end
                end
                m_valid = 1; m_data = best; m_dist = bd;
                if (bd <= THRESHOLD) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == MISS_LIMIT) begin m_lock = 0; m_fill = 0; m_miss = 0; end
                end
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, "_valid"}, int'(bus.outValid), int'(m_valid));
        check({tag, "_lock"},  int'(bus.outLock),  int'(m_lock));
        check({tag, "_data"},  int'(bus.outData),  m_data);
`ifdef DESPREADER_DIST_OUT_EN
        check({tag, "_dist"},  int'(bus.outDistance), m_dist);
`endif
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_valid"}, int'(bus.outValid), 0);
        check({tag, "_lock"},  int'(bus.outLock),  0);
        check({tag, "_data"},  int'(bus.outData),  0);
`ifdef DESPREADER_DIST_OUT_EN
        check({tag, "_dist"},  int'(bus.outDistance), 0);
`endif
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic send_chip(bit c, int gap);
        bus.inEnable = 1'b1;
        bus.inChip   = c;
        @(posedge clk);
        model_step(c);
        #1;
        check_model("strobe");
        bus.inEnable = 1'b0;
        bus.inChip   = 1'($urandom);
        repeat (gap) begin
            @(posedge clk);
            m_valid = 0;
            #1;
            check_model("gap");
        end
    endtask

    task automatic send_word(int sym, logic [31:0] flip, int gap);
        bit c;
        for (int i = 0; i < 32; i++) begin
            c = (sym < 0) ? 1'b0 : pn_chip(sym, i);
            c = c ^ flip[i];
            send_chip(c, (i == 31) ? 0 : gap);
        end
    endtask

    vec_t vecs[$];

    initial begin
        bus.inEnable = 1'b0;
        bus.inChip   = 1'b0;
        model_reset();

        // Reset held with strobes toggling.
        for (int i = 0; i < 5; i++) begin
            bus.inEnable = 1'(i % 2);
            bus.inChip   = 1'($urandom);
            @(posedge clk);
            #1;
            check_reset_vals("reset");
        end
        bus.inEnable = 1'b0;
        rst_n = 1'b1;

        vecs.push_back(vec_t'{0,  32'h0,        1'b0, -1, 1'b1,  0});
        vecs.push_back(vec_t'{0,  32'h0,        1'b1,  0, 1'b1,  0});
        vecs.push_back(vec_t'{0,  32'h0,        1'b1,  0, 1'b1,  0});
        vecs.push_back(vec_t'{0,  32'h0,        1'b1,  0, 1'b1,  0});
        vecs.push_back(vec_t'{0,  32'h0,        1'b1,  0, 1'b1,  0});
        vecs.push_back(vec_t'{7,  32'h0,        1'b1,  7, 1'b1,  0});
        vecs.push_back(vec_t'{8,  32'h0,        1'b1,  8, 1'b1,  0});
        vecs.push_back(vec_t'{15, 32'h0,        1'b1, 15, 1'b1,  0});
        vecs.push_back(vec_t'{3,  32'h02108421, 1'b1,  3, 1'b1,  6});
        vecs.push_back(vec_t'{3,  32'h42108421, 1'b1, -1, 1'b1, -1});
        vecs.push_back(vec_t'{0,  32'h0,        1'b1,  0, 1'b1,  0});
        vecs.push_back(vec_t'{-1, 32'h0,        1'b1, -1, 1'b1, -1});
        vecs.push_back(vec_t'{-1, 32'h0,        1'b1, -1, 1'b1, -1});
        vecs.push_back(vec_t'{-1, 32'h0,        1'b1, -1, 1'b0, -1});
        vecs.push_back(vec_t'{0,  32'h0,        1'b0, -1, 1'b1,  0});
        vecs.push_back(vec_t'{0,  32'h0,        1'b1,  0, 1'b1,  0});

        // Misaligned start: 13 junk chips ahead of the first PN[0].
        for (int i = 0; i < 13; i++) begin
            send_chip(1'($urandom), 0);
            check("junk_nolock", int'(bus.outLock), 0);
        end

        foreach (vecs[v]) begin
            send_word(vecs[v].sym, vecs[v].flip, 0);
            check($sformatf("vec%0d_valid", v), int'(bus.outValid), int'(vecs[v].exp_valid));
            check($sformatf("vec%0d_lock", v),  int'(bus.outLock),  int'(vecs[v].exp_lock));
            if (vecs[v].exp_data >= 0)
                check($sformatf("vec%0d_data", v), int'(bus.outData), vecs[v].exp_data);
`ifdef DESPREADER_DIST_OUT_EN
            if (vecs[v].exp_dist >= 0)
                check($sformatf("vec%0d_dist", v), int'(bus.outDistance), vecs[v].exp_dist);
`endif
        end

        // Gapped strobes: one strobe every fourth cycle.
        send_word(5, 32'h0, 3);
        check("gapped_valid5", int'(bus.outValid), 1);
        check("gapped_data5",  int'(bus.outData),  5);
        send_chip(pn_chip(10, 0), 3);
        check("gapped_pulse_width", int'(bus.outValid), 0);
        for (int i = 1; i < 32; i++) send_chip(pn_chip(10, i), (i == 31) ? 0 : 3);
        check("gapped_valid10", int'(bus.outValid), 1);
        check("gapped_data10",  int'(bus.outData),  10);

        // Randomized words against the model, with one reset mid-symbol.
        for (int w = 0; w < 60; w++) begin
            int          sym;
            int          nf;
            int          gap;
            logic [31:0] m;
            sym = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) sym = -1;
            nf  = $urandom_range(0, 9);
            gap = $urandom_range(0, 2);
            m   = '0;
            for (int f = 0; f < nf; f++) m[$urandom_range(0, 31)] = 1'b1;
            if ($urandom_range(0, 7) == 0)
                repeat ($urandom_range(1, 5)) send_chip(1'($urandom), gap);
            send_word(sym, m, gap);
            if (w == 30) begin
                for (int i = 0; i < 10; i++) send_chip(pn_chip(0, i), 0);
                rst_n = 1'b0;
                #2;
                check_reset_vals("async_reset");
                @(posedge clk);
                #1;
                check_reset_vals("reset_hold");
                model_reset();
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chip_despreader.md
# chip_despreader

Receive-side DSSS despreader for the 2.4 GHz O-QPSK Zigbee chain. It is the counterpart of the coder's symbol-to-chip spreader. It sits between the CDR, which delivers one recovered chip per strobe, and the outFIFO, which takes 4-bit symbols. It hunts for chip alignment on the preamble, then locks and correlates each 32-chip word against the 16 standard PN sequences. It emits the closest symbol and drops lock after repeated poor matches.

## Interface
Parameters:
- THRESHOLD, 6: maximum Hamming distance (chips) accepted as a valid match.
- MISS_LIMIT, 3: consecutive over-threshold symbols in TRACK before returning to HUNT.

Ports:
- inClock  in  1  system clock; all logic on rising edge.
- inReset  in  1  asynchronous, active-low reset.
- inEnable  in  1  chip strobe from CDR; one chip consumed per cycle it is high.
- inChip  in  1  chip value, valid when inEnable=1.
- outData  out  4  decoded symbol, held until next outValid.
- outValid  out  1  one-cycle pulse; outData updated the same cycle.
- outLock  out  1  high while in TRACK.
- outDistance  out  6  min Hamming distance of the last symbol (0..32). Present only with DESPREADER_DIST_OUT_EN.

## Operation
- Chip order: c0 received first. Each strobe shifts inChip into a 32-bit window, so the window holds the last 32 chips.
- PN table: symbol 0 = c0..c31 = 11011001110000110101001000101110.
  - Symbol k (1..7): symbol 0 cyclically delayed by 4k chips; chip i = symbol-0 chip (i−4k) mod 32.
  - Symbol k+8 (0..7): symbol k with odd-indexed chips inverted.
- Distance: popcount(window XOR PN[k]), 6 bits, unsigned. Min search is over k = 0..15. Ties go to the lowest k.
- FSM has two states, HUNT and TRACK. Reset state is HUNT.
- HUNT:
  - fill counter counts strobes, saturating at 32.
  - On a strobe with fill = 32 (including the current chip), compare window to PN[0] only.
  - If distance ≤ THRESHOLD: go to TRACK, chip counter ← 0, miss counter ← 0. No outValid for the aligning symbol.
- TRACK:
  - chip counter increments on each strobe, wraps 31→0.
  - On the strobe carrying chip 31: full 16-way search; outData ← argmin; outValid pulse.
  - If min ≤ THRESHOLD: miss counter ← 0.
  - Otherwise: miss counter +1. The symbol is still output.
  - When the miss counter reaches MISS_LIMIT: go to HUNT, fill ← 0, miss ← 0, outLock falls.
- Preamble symbols after lock are output as 0. SFD detection is downstream.
- inEnable low: no state change. outValid never asserts without a strobe in the previous cycle.
- Reset mid-operation clears the window, all counters and the state at once. The partially collected symbol is discarded.

## Timing
- Reset values: outData = 0, outValid = 0, outLock = 0, outDistance = 0. Window, fill, chip and miss counters = 0.
- Latency: outValid is high in the cycle after the clock edge that sampled chip 31's strobe, i.e. registered, 1 cycle after the strobe.
- outLock rises on the edge that samples the matching HUNT strobe. It falls on the edge that samples the MISS_LIMIT-th bad symbol's chip 31. The final outValid of that symbol still fires.
- Back-to-back strobes (inEnable held high) are supported at full clock rate. Minimum symbol spacing is 32 cycles.
- The search is combinational off the window and is registered once. No multicycle paths.

## Configuration
- DESPREADER_DIST_OUT_EN defined:
  - outDistance port exists.
  - It is registered with outData on each TRACK symbol, and in HUNT on the aligning match.
- Not defined: port is absent, and the distance is used internally only.
- Functional behaviour of all other outputs is identical in both builds.

## Test plan
- Reset: hold inReset=0 for 5 cycles with strobes toggling → all outputs 0 and outLock=0 throughout.
- Clean lock: 5 × PN[0] then PN[7], PN[8], PN[15], all strobes continuous:
  - outLock rises at chip 31 of the first PN[0].
  - outValid then pulses 4× with outData = 0, then 7, 8, 15.
  - outDistance = 0 on every pulse.
- Misaligned start: 13 random chips, then PN[0] repeated → lock occurs exactly at the end of the first complete PN[0]; no false lock during the random chips.
- Noise tolerance: PN[3] with 6 chips flipped → outData = 3, distance 6, lock kept. With 7 flipped → symbol still output, miss counter increments.
- Lock loss: after lock, 3 consecutive all-zero words. These have distance ≥ 12 from every PN for MISS_LIMIT = 3. Expect 3 outValid pulses, then outLock = 0 after the third. PN[0] ×2 then re-locks.
- Gapped strobes: inEnable high 1 cycle in 4 for 2 symbols → same outData sequence as continuous; outValid exactly 1 cycle after each 32nd strobe.
